// File: rtl/stim_check_pkg.sv
// Shared types and width helpers for the stimulus/check controller.
// The width helpers clamp so that single-entry configurations still get 1-bit fields.
package stim_check_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_CHECK  = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/stim_check_ctrl_vec_store.sv
// Test-vector memory: one synchronous write port and one combinational read port.
// Out-of-range read addresses return zero; the contents are deliberately not reset.
module vec_store #(
    parameter int NUM_VEC = 9,
    parameter int VEC_W   = 32,
    parameter int ADDR_W  = 4
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [VEC_W-1:0]  wr_dat,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [VEC_W-1:0]  rd_dat
);

    logic [VEC_W-1:0] mem_q [NUM_VEC];

    always_ff @(posedge clk) begin
        if (wr_en && (32'(wr_addr) < NUM_VEC)) begin
            mem_q[wr_addr] <= wr_dat;
        end
    end

    always_comb begin
        rd_dat = '0;
        if (32'(rd_addr) < NUM_VEC) begin
            rd_dat = mem_q[rd_addr];
        end
    end

endmodule

// File: rtl/stim_check_ctrl.sv
// Steps through the stored vectors, drives each onto the DUT for SETTLE_CYC+1 cycles,
// then compares c_out with the expected result and accumulates pass/fail status.
module stim_check_ctrl
    import stim_check_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int MODE_W     = 8,
    parameter int NUM_VEC    = 9,
    parameter int SETTLE_CYC = 4
) (
    input  logic                              emu_clk,
    input  logic                              emu_rst,
    input  logic                              start,
    input  logic                              stop_on_fail,
    input  logic                              vec_we,
    input  logic [idx_width(NUM_VEC)-1:0]     vec_addr,
    input  logic [DATA_W-1:0]                 vec_a,
    input  logic [DATA_W-1:0]                 vec_b,
    input  logic [MODE_W-1:0]                 vec_mode,
    input  logic [DATA_W-1:0]                 vec_expct,
    output logic [DATA_W-1:0]                 a_in,
    output logic [DATA_W-1:0]                 b_in,
    output logic [MODE_W-1:0]                 mode_in,
    input  logic [DATA_W-1:0]                 c_out,
    output logic                              busy,
    output logic                              done,
    output logic [cnt_width(NUM_VEC)-1:0]     pass_cnt,
    output logic [cnt_width(NUM_VEC)-1:0]     fail_cnt,
    output logic                              fail_seen,
    output logic [idx_width(NUM_VEC)-1:0]     first_fail_idx
);

    localparam int IDX_W = idx_width(NUM_VEC);
    localparam int CNT_W = cnt_width(NUM_VEC);
    localparam int SET_W = idx_width(SETTLE_CYC);
    localparam int VEC_W = 3 * DATA_W + MODE_W;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VEC - 1);
    localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE_CYC - 1);

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [SET_W-1:0]   set_cnt_q, set_cnt_d;
    logic [DATA_W-1:0]  a_q, a_d, b_q, b_d, exp_q, exp_d;
    logic [MODE_W-1:0]  mode_q, mode_d;
    logic [CNT_W-1:0]   pass_q, pass_d, fail_q, fail_d;
    logic               fail_seen_q, fail_seen_d;
    logic [IDX_W-1:0]   ffi_q, ffi_d;
    logic               busy_q, busy_d, done_q, done_d;

    logic               start_ok;
    logic               mism;
    logic               wr_en;
    logic [IDX_W-1:0]   rd_addr;
    logic [VEC_W-1:0]   rd_dat;
    logic [DATA_W-1:0]  rd_a, rd_b, rd_exp;
    logic [MODE_W-1:0]  rd_mode;

    // Writes are blocked for the whole run so the vector set cannot change under a check.
    assign wr_en = vec_we && !busy_q;
    assign {rd_a, rd_b, rd_mode, rd_exp} = rd_dat;

    vec_store #(
        .NUM_VEC (NUM_VEC),
        .VEC_W   (VEC_W),
        .ADDR_W  (IDX_W)
    ) u_vec_store (
        .clk     (emu_clk),
        .wr_en   (wr_en),
        .wr_addr (vec_addr),
        .wr_dat  ({vec_a, vec_b, vec_mode, vec_expct}),
        .rd_addr (rd_addr),
        .rd_dat  (rd_dat)
    );

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        set_cnt_d   = set_cnt_q;
        a_d         = a_q;
        b_d         = b_q;
        mode_d      = mode_q;
        exp_d       = exp_q;
        pass_d      = pass_q;
        fail_d      = fail_q;
        fail_seen_d = fail_seen_q;
        ffi_d       = ffi_q;

        start_ok = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
        mism     = (c_out != exp_q);
        // The read port serves vector 0 on a start and the next vector otherwise.
        rd_addr  = start_ok ? '0 : idx_q + IDX_W'(1);

        if (start_ok) begin
            state_d     = ST_SETTLE;
            idx_d       = '0;
            set_cnt_d   = '0;
            a_d         = rd_a;
            b_d         = rd_b;
            mode_d      = rd_mode;
            exp_d       = rd_exp;
            pass_d      = '0;
            fail_d      = '0;
            fail_seen_d = 1'b0;
            ffi_d       = '0;
        end else begin
            case (state_q)
                ST_SETTLE: begin
                    if (set_cnt_q == SET_LAST) begin
                        state_d = ST_CHECK;
                    end else begin
                        set_cnt_d = set_cnt_q + SET_W'(1);
                    end
                end
                ST_CHECK: begin
                    if (mism) begin
                        fail_d = fail_q + CNT_W'(1);
                        if (!fail_seen_q) begin
                            fail_seen_d = 1'b1;
                            ffi_d       = idx_q;
                        end
                    end else begin
                        pass_d = pass_q + CNT_W'(1);
                    end
                    if ((idx_q == LAST_IDX) || (stop_on_fail && mism)) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d   = ST_SETTLE;
                        idx_d     = idx_q + IDX_W'(1);
                        set_cnt_d = '0;
                        a_d       = rd_a;
                        b_d       = rd_b;
                        mode_d    = rd_mode;
                        exp_d     = rd_exp;
                    end
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end

        busy_d = (state_d == ST_SETTLE) || (state_d == ST_CHECK);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge emu_clk or posedge emu_rst) begin
        if (emu_rst) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            set_cnt_q   <= '0;
            a_q         <= '0;
            b_q         <= '0;
            mode_q      <= '0;
            exp_q       <= '0;
            pass_q      <= '0;
            fail_q      <= '0;
            fail_seen_q <= 1'b0;
            ffi_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            set_cnt_q   <= set_cnt_d;
            a_q         <= a_d;
            b_q         <= b_d;
            mode_q      <= mode_d;
            exp_q       <= exp_d;
            pass_q      <= pass_d;
            fail_q      <= fail_d;
            fail_seen_q <= fail_seen_d;
            ffi_q       <= ffi_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign a_in           = a_q;
    assign b_in           = b_q;
    assign mode_in        = mode_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign pass_cnt       = pass_q;
    assign fail_cnt       = fail_q;
    assign fail_seen      = fail_seen_q;
    assign first_fail_idx = ffi_q;

endmodule

// File: tb/tb_stim_check_ctrl.sv
// Bench for stim_check_ctrl: a table-driven reference DUT answers each driven vector,
// and directed scenarios check counts, done timing, early stop, ignored inputs and reset.
module tb_stim_check_ctrl;

    logic       emu_clk = 1'b0;
    logic       emu_rst = 1'b1;
    logic       start = 1'b0;
    logic       stop_on_fail = 1'b0;
    logic       vec_we = 1'b0;
    logic [3:0] vec_addr = '0;
    logic [7:0] vec_a = '0, vec_b = '0, vec_mode = '0, vec_expct = '0;
    logic [7:0] a_in, b_in, mode_in, c_out;
    logic       busy, done, fail_seen;
    logic [3:0] pass_cnt, fail_cnt, first_fail_idx;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] ref_a [9] = '{8'd12, 8'd45, 8'd10, 8'd3, 8'd9, 8'd9, 8'd2, 8'd3, 8'd56};
    logic [7:0] ref_b [9] = '{8'd34, 8'd10, 8'd44, 8'd7, 8'd1, 8'd1, 8'd32, 8'd3, 8'd78};
    logic [7:0] ref_c [9] = '{8'd46, 8'd35, 8'd34, 8'd21, 8'd4, 8'd18, 8'd8, 8'd24, 8'd42};

    always #5 emu_clk = ~emu_clk;

    // Correct DUT: each mode has one known operand pair and result; anything else answers 0xFF.
    always_comb begin
        c_out = 8'hFF;
        if (mode_in < 8'd9) begin
            if (a_in == ref_a[int'(mode_in)] && b_in == ref_b[int'(mode_in)]) begin
                c_out = ref_c[int'(mode_in)];
            end
        end
    end

    stim_check_ctrl #(
        .DATA_W(8), .MODE_W(8), .NUM_VEC(9), .SETTLE_CYC(4)
    ) dut (
        .emu_clk(emu_clk), .emu_rst(emu_rst), .start(start), .stop_on_fail(stop_on_fail),
        .vec_we(vec_we), .vec_addr(vec_addr), .vec_a(vec_a), .vec_b(vec_b),
        .vec_mode(vec_mode), .vec_expct(vec_expct),
        .a_in(a_in), .b_in(b_in), .mode_in(mode_in), .c_out(c_out),
        .busy(busy), .done(done), .pass_cnt(pass_cnt), .fail_cnt(fail_cnt),
        .fail_seen(fail_seen), .first_fail_idx(first_fail_idx)
    );

    task automatic write_vec(input int i, input int e);
        vec_we = 1'b1; vec_addr = 4'(i); vec_a = ref_a[i]; vec_b = ref_b[i];
        vec_mode = 8'(i); vec_expct = 8'(e);
        @(posedge emu_clk); #1;
        vec_we = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge emu_clk); #1;
        start = 1'b0;
    endtask

    // Counts cycles from the accepted start edge until done; optionally injects start+write mid-run.
    task automatic wait_done(output int cycles, input int inject_at);
        cycles = 0;
        while (done !== 1'b1 && cycles < 200) begin
            @(posedge emu_clk); #1;
            cycles++;
            if (cycles == inject_at) begin
                start = 1'b1; vec_we = 1'b1; vec_addr = 4'd0; vec_a = 8'd99; vec_expct = 8'd99;
            end else if (cycles == inject_at + 1) begin
                start = 1'b0; vec_we = 1'b0;
            end
        end
        n_cmp++;
        if (done !== 1'b1) begin
            n_err++; $display("FAIL wait_done: done not seen after %0d cycles", cycles);
        end
    endtask

    task automatic check_all_zero(input string tag);
        n_cmp++; if (a_in !== 8'd0) begin n_err++; $display("FAIL %s a_in: got %0d want 0", tag, a_in); end
        n_cmp++; if (b_in !== 8'd0) begin n_err++; $display("FAIL %s b_in: got %0d want 0", tag, b_in); end
        n_cmp++; if (mode_in !== 8'd0) begin n_err++; $display("FAIL %s mode_in: got %0d want 0", tag, mode_in); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL %s busy: got %b want 0", tag, busy); end
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL %s done: got %b want 0", tag, done); end
        n_cmp++; if (pass_cnt !== 4'd0) begin n_err++; $display("FAIL %s pass_cnt: got %0d want 0", tag, pass_cnt); end
        n_cmp++; if (fail_cnt !== 4'd0) begin n_err++; $display("FAIL %s fail_cnt: got %0d want 0", tag, fail_cnt); end
        n_cmp++; if (fail_seen !== 1'b0) begin n_err++; $display("FAIL %s fail_seen: got %b want 0", tag, fail_seen); end
        n_cmp++; if (first_fail_idx !== 4'd0) begin n_err++; $display("FAIL %s first_fail_idx: got %0d want 0", tag, first_fail_idx); end
    endtask

    task automatic test_reset();
        emu_rst = 1'b1;
        repeat (2) @(posedge emu_clk);
        #1;
        check_all_zero("reset");
        emu_rst = 1'b0;
        for (int i = 0; i < 9; i++) write_vec(i, int'(ref_c[i]));
    endtask

    task automatic test_full_pass();
        int cyc;
        pulse_start();
        wait_done(cyc, -10);
        n_cmp++; if (cyc !== 45) begin n_err++; $display("FAIL full_pass latency: got %0d want 45", cyc); end
        n_cmp++; if (pass_cnt !== 4'd9) begin n_err++; $display("FAIL full_pass pass_cnt: got %0d want 9", pass_cnt); end
        n_cmp++; if (fail_cnt !== 4'd0) begin n_err++; $display("FAIL full_pass fail_cnt: got %0d want 0", fail_cnt); end
        n_cmp++; if (fail_seen !== 1'b0) begin n_err++; $display("FAIL full_pass fail_seen: got %b want 0", fail_seen); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL full_pass busy: got %b want 0", busy); end
    endtask

    task automatic test_fail_continue();
        int cyc;
        write_vec(3, 20);
        stop_on_fail = 1'b0;
        pulse_start();
        wait_done(cyc, -10);
        n_cmp++; if (cyc !== 45) begin n_err++; $display("FAIL fail_continue latency: got %0d want 45", cyc); end
        n_cmp++; if (pass_cnt !== 4'd8) begin n_err++; $display("FAIL fail_continue pass_cnt: got %0d want 8", pass_cnt); end
        n_cmp++; if (fail_cnt !== 4'd1) begin n_err++; $display("FAIL fail_continue fail_cnt: got %0d want 1", fail_cnt); end
        n_cmp++; if (fail_seen !== 1'b1) begin n_err++; $display("FAIL fail_continue fail_seen: got %b want 1", fail_seen); end
        n_cmp++; if (first_fail_idx !== 4'd3) begin n_err++; $display("FAIL fail_continue first_fail_idx: got %0d want 3", first_fail_idx); end
    endtask

    task automatic test_stop_on_fail();
        int cyc;
        stop_on_fail = 1'b1;
        pulse_start();
        wait_done(cyc, -10);
        n_cmp++; if (cyc !== 20) begin n_err++; $display("FAIL stop_on_fail latency: got %0d want 20", cyc); end
        n_cmp++; if (pass_cnt !== 4'd3) begin n_err++; $display("FAIL stop_on_fail pass_cnt: got %0d want 3", pass_cnt); end
        n_cmp++; if (fail_cnt !== 4'd1) begin n_err++; $display("FAIL stop_on_fail fail_cnt: got %0d want 1", fail_cnt); end
        n_cmp++; if (first_fail_idx !== 4'd3) begin n_err++; $display("FAIL stop_on_fail first_fail_idx: got %0d want 3", first_fail_idx); end
        repeat (3) @(posedge emu_clk);
        #1;
        n_cmp++; if (a_in !== 8'd3) begin n_err++; $display("FAIL stop_on_fail hold a_in: got %0d want 3", a_in); end
        n_cmp++; if (b_in !== 8'd7) begin n_err++; $display("FAIL stop_on_fail hold b_in: got %0d want 7", b_in); end
        n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL stop_on_fail hold done: got %b want 1", done); end
        n_cmp++; if (pass_cnt !== 4'd3) begin n_err++; $display("FAIL stop_on_fail hold pass_cnt: got %0d want 3", pass_cnt); end
        stop_on_fail = 1'b0;
        write_vec(3, 21);
    endtask

    task automatic test_ignore_busy();
        int cyc;
        pulse_start();
        wait_done(cyc, 7);
        n_cmp++; if (cyc !== 45) begin n_err++; $display("FAIL ignore_busy latency: got %0d want 45", cyc); end
        n_cmp++; if (pass_cnt !== 4'd9) begin n_err++; $display("FAIL ignore_busy pass_cnt: got %0d want 9", pass_cnt); end
        pulse_start();
        n_cmp++; if (a_in !== 8'd12) begin n_err++; $display("FAIL ignore_busy rerun a_in: got %0d want 12", a_in); end
        wait_done(cyc, -10);
        n_cmp++; if (pass_cnt !== 4'd9) begin n_err++; $display("FAIL ignore_busy rerun pass_cnt: got %0d want 9", pass_cnt); end
    endtask

    task automatic test_reset_mid_run();
        int cyc;
        pulse_start();
        repeat (22) @(posedge emu_clk);
        #1;
        n_cmp++; if (a_in !== 8'd9 || mode_in !== 8'd4) begin
            n_err++; $display("FAIL reset_mid_run pre: got a_in=%0d mode=%0d want 9/4", a_in, mode_in);
        end
        emu_rst = 1'b1;
        #1;
        check_all_zero("reset_mid_run");
        @(posedge emu_clk); #1;
        emu_rst = 1'b0;
        pulse_start();
        wait_done(cyc, -10);
        n_cmp++; if (cyc !== 45) begin n_err++; $display("FAIL reset_rerun latency: got %0d want 45", cyc); end
        n_cmp++; if (pass_cnt !== 4'd9) begin n_err++; $display("FAIL reset_rerun pass_cnt: got %0d want 9", pass_cnt); end
    endtask

    task automatic test_restart_from_done();
        int cyc;
        pulse_start();
        n_cmp++; if (pass_cnt !== 4'd0) begin n_err++; $display("FAIL restart pass_cnt: got %0d want 0", pass_cnt); end
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL restart busy: got %b want 1", busy); end
        n_cmp++; if (a_in !== 8'd12) begin n_err++; $display("FAIL restart a_in: got %0d want 12", a_in); end
        wait_done(cyc, -10);
        // Start and a write to vector 0 on the same edge: old contents must be driven.
        start = 1'b1; vec_we = 1'b1; vec_addr = 4'd0; vec_a = 8'd77; vec_b = 8'd34;
        vec_mode = 8'd0; vec_expct = 8'd46;
        @(posedge emu_clk); #1;
        start = 1'b0; vec_we = 1'b0;
        n_cmp++; if (a_in !== 8'd12) begin n_err++; $display("FAIL rbw a_in: got %0d want 12", a_in); end
        wait_done(cyc, -10);
        n_cmp++; if (pass_cnt !== 4'd9) begin n_err++; $display("FAIL rbw pass_cnt: got %0d want 9", pass_cnt); end
        pulse_start();
        n_cmp++; if (a_in !== 8'd77) begin n_err++; $display("FAIL rbw next a_in: got %0d want 77", a_in); end
    endtask

    initial begin
        test_reset();
        test_full_pass();
        test_fail_continue();
        test_stop_on_fail();
        test_ignore_busy();
        test_reset_mid_run();
        test_restart_from_done();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/stim_check_ctrl.md
STIM_CHECK_CTRL -- requirements
Module: stim_check_ctrl

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, the width of operands and result.
REQ-002 The block SHALL have parameter MODE_W, default 8, the width of the mode word.
REQ-003 The block SHALL have parameter NUM_VEC, default 9, the number of stored test vectors (at least 1).
REQ-004 The block SHALL have parameter SETTLE_CYC, default 4, the number of cycles a vector is held before checking (at least 1).
REQ-005 The block SHALL have port emu_clk, input, 1 bit: the single clock.
REQ-006 The block SHALL have port emu_rst, input, 1 bit: asynchronous, active-high reset.
REQ-007 The block SHALL have port start, input, 1 bit: a run request, sampled on rising emu_clk.
REQ-008 The block SHALL have port stop_on_fail, input, 1 bit: when high, the run ends at the first mismatch.
REQ-009 The block SHALL have vector write ports: vec_we (input, 1), vec_addr (input, $clog2(NUM_VEC)), vec_a (input, DATA_W), vec_b (input, DATA_W), vec_mode (input, MODE_W) and vec_expct (input, DATA_W).
REQ-010 The block SHALL have DUT-drive outputs a_in (DATA_W), b_in (DATA_W) and mode_in (MODE_W).
REQ-011 The block SHALL have port c_out, input, DATA_W: the DUT result.
REQ-012 The block SHALL have status outputs busy (1), done (1), pass_cnt (CNT_W), fail_cnt (CNT_W), fail_seen (1) and first_fail_idx ($clog2(NUM_VEC)), where CNT_W = $clog2(NUM_VEC+1).

Function
REQ-013 The block SHALL implement the state machine IDLE -> SETTLE -> CHECK -> (SETTLE | DONE), with DONE -> SETTLE on start.
REQ-014 The block SHALL accept start only in IDLE or DONE; a start in SETTLE or CHECK SHALL be ignored.
REQ-015 On an accepted start, the same edge SHALL clear the counters, fail_seen and first_fail_idx, set idx=0, register vector 0 onto a_in/b_in/mode_in and enter SETTLE.
REQ-016 SETTLE SHALL last exactly SETTLE_CYC cycles, followed by one CHECK cycle, so each vector is driven stable for SETTLE_CYC+1 cycles.
REQ-017 In CHECK, the block SHALL compare c_out against the expected value using full-width equality; an equal value increments pass_cnt, otherwise fail_cnt.
REQ-018 On the first mismatch of a run, the block SHALL set fail_seen=1 and first_fail_idx=idx; later mismatches SHALL NOT change first_fail_idx.
REQ-019 At the CHECK edge, if idx==NUM_VEC-1, or if stop_on_fail is high and the current vector mismatched, the block SHALL go to DONE; otherwise it SHALL increment idx, register the next vector and return to SETTLE.
REQ-020 For a full run with no early stop, done SHALL rise exactly NUM_VEC*(SETTLE_CYC+1) cycles after the accepted start edge.
REQ-021 busy SHALL be 1 exactly in SETTLE and CHECK; done SHALL be 1 exactly in DONE.
REQ-022 In DONE and IDLE, a_in/b_in/mode_in and all status outputs SHALL hold their values.
REQ-023 A vector write with vec_we=1 SHALL take effect at the edge when the block is not busy and SHALL be ignored while busy.
REQ-024 The counters SHALL never wrap, because their maximum value is NUM_VEC.
REQ-025 When the vector written is the one currently being driven and start occurs on the same edge, the block SHALL drive the pre-write contents (read-before-write).

Reset
REQ-026 While emu_rst is high, the block SHALL asynchronously force state=IDLE, idx=0, a_in=b_in=mode_in=0, busy=done=fail_seen=0, pass_cnt=fail_cnt=0 and first_fail_idx=0.
REQ-027 A reset during a run SHALL abort the run immediately; vector memory contents SHALL NOT be reset.

Structure
REQ-028 The state enumeration and the CNT_W/index-width helper functions SHALL live in package stim_check_pkg.
REQ-029 Vector storage SHALL be a sub-module vec_store (NUM_VEC entries of {a, b, mode, expct}, one synchronous write port, one combinational read port), instantiated once.

Verification
REQ-030 Verification SHALL load the 9 vectors (12,34,0,46), (45,10,1,35), (10,44,2,34), (3,7,3,21), (9,1,4,4), (9,1,5,18), (2,32,6,8), (3,3,7,24) and (56,78,8,42) with a correct DUT model, then pulse start -> pass_cnt=9, fail_cnt=0, fail_seen=0, and done 45 cycles after start.
REQ-031 Verification SHALL run the same set with vector 3 expct=20 and stop_on_fail=0 -> pass_cnt=8, fail_cnt=1, first_fail_idx=3, done after 45 cycles.
REQ-032 Verification SHALL run the same corruption with stop_on_fail=1 -> pass_cnt=3, fail_cnt=1, done 20 cycles after start, and a_in=3, b_in=7 held.
REQ-033 Verification SHALL pulse start again mid-run and attempt vec_we while busy -> both ignored, and memory is unchanged on rerun.
REQ-034 Verification SHALL assert emu_rst during SETTLE of vector 4 -> all outputs 0 immediately; a subsequent start reruns from vector 0 with 9 passes.
REQ-035 Verification SHALL restart from DONE -> counters clear on the start edge and a_in=12 on the next cycle.
